// File: rtl/press_gen_pkg.sv
// Shared types and width helpers for the pulse-to-press generator.
package press_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  // Timer must hold max(HOLD,GAP)-1; keep at least one bit for HOLD=GAP=1.
  function automatic int tmr_width(input int hold, input int gap);
    int m;
    m = (hold > gap) ? hold : gap;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int pend_width(input int qdepth);
    return $clog2(qdepth + 1);
  endfunction

endpackage

// File: rtl/press_gen_if.sv
// Event-in / press-out bundle of press_gen; master is the event source.
interface press_gen_if import press_gen_pkg::*; #(
  parameter int QDEPTH = 3
);
  localparam int PW = pend_width(QDEPTH);

  logic          pulse;
  logic          press;
  logic          busy;
  logic [PW-1:0] pend;
  logic          ovf;

  modport master (output pulse, input press, busy, pend, ovf);
  modport slave  (input pulse, output press, busy, pend, ovf);
endinterface

// File: rtl/press_timer.sv
// Loadable down-counter that parks at zero and flags it.
module press_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)               cnt <= '0;
    else if (load)         cnt <= load_val;
    else if (cnt != '0)    cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/press_gen.sv
// Stretches event pulses into HOLD-long presses separated by GAP low cycles.
// Build macro PRESS_GEN_QUEUE_EN enables the pending-event queue.
module press_gen import press_gen_pkg::*; #(
  parameter int HOLD   = 8,
  parameter int GAP    = 4,
  parameter int QDEPTH = 3
) (
  input  logic        clk,
  input  logic        rst,
  press_gen_if.slave  bus
);
  localparam int TW = tmr_width(HOLD, GAP);
  localparam int PW = pend_width(QDEPTH);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP - 1);

  state_t        state;
  logic          press_q, busy_q, ovf_q;
  logic [PW-1:0] pend_q;
  logic          tzero, gap_end, replay, enq, deq, full, drop, load;
  logic [TW-1:0] load_val;

  // On the final GAP cycle a fresh pulse either starts the next HOLD itself
  // (queue empty) or takes the slot freed by the replayed event.
  always_comb begin
    gap_end  = (state == S_GAP) && tzero;
    deq      = gap_end && (pend_q != '0);
    replay   = gap_end && (deq || bus.pulse);
    enq      = bus.pulse && (state != S_IDLE) && !(gap_end && (pend_q == '0));
    drop     = enq && full && !deq;
    load     = ((state == S_IDLE) && bus.pulse) || replay ||
               ((state == S_HOLD) && tzero);
    load_val = (state == S_HOLD) ? GAP_LD : HOLD_LD;
  end

`ifdef PRESS_GEN_QUEUE_EN
  localparam logic [PW-1:0] QMAX = PW'(QDEPTH);

  assign full = (pend_q == QMAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          pend_q <= '0;
    else if (enq && !deq && !full)    pend_q <= pend_q + 1'b1;
    else if (deq && !enq)             pend_q <= pend_q - 1'b1;
  end
`else
  assign full   = 1'b1;
  assign pend_q = '0;
`endif

  press_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .zero     (tzero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      press_q <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (drop) ovf_q <= 1'b1;
      case (state)
        S_IDLE: if (bus.pulse) begin
          state   <= S_HOLD;
          press_q <= 1'b1;
          busy_q  <= 1'b1;
        end
        S_HOLD: if (tzero) begin
          state   <= S_GAP;
          press_q <= 1'b0;
        end
        S_GAP: if (tzero) begin
          if (replay) begin
            state   <= S_HOLD;
            press_q <= 1'b1;
          end else begin
            state   <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          press_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.press = press_q;
  assign bus.busy  = busy_q;
  assign bus.pend  = pend_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_press_gen.sv
// Scoreboard bench for press_gen; follows PRESS_GEN_QUEUE_EN like the RTL.
module tb_press_gen;
  localparam int H = 8;
  localparam int G = 4;
  localparam int Q = 3;
`ifdef PRESS_GEN_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  press_gen_if #(.QDEPTH(Q)) bus ();

  press_gen #(.HOLD(H), .GAP(G), .QDEPTH(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int acc_arr[$];
  int acc_start[$];
  int exp_q[$];
  int drop_cyc;
  bit prev_press;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // A press can start no earlier than the cycle after its pulse and no
  // earlier than HOLD+GAP after the previous accepted press.
  function automatic void model_pulse(input int c);
    int cnt;
    int start;
    bit ok;
    cnt   = 0;
    start = c + 1;
    foreach (acc_start[i]) if (acc_start[i] > c + 1) cnt++;
    if (acc_start.size() > 0 && acc_start[$] + H + G > start)
      start = acc_start[$] + H + G;
    ok = QEN ? (cnt < Q) : (start == c + 1);
    if (ok) begin
      acc_arr.push_back(c);
      acc_start.push_back(start);
      exp_q.push_back(start);
    end else if (drop_cyc < 0) begin
      drop_cyc = c;
    end
  endfunction

  function automatic void model_out(input int k, output int p, output int b,
                                    output int pd, output int o);
    p = 0; b = 0; pd = 0;
    foreach (acc_start[i]) begin
      if (acc_start[i] <= k && k < acc_start[i] + H)     p = 1;
      if (acc_start[i] <= k && k < acc_start[i] + H + G) b = 1;
      if (acc_arr[i] < k && acc_start[i] > k)            pd++;
    end
    o = (drop_cyc >= 0 && drop_cyc < k) ? 1 : 0;
  endfunction

  task automatic run_scn(input string name, input logic [127:0] pat,
                         input int rst_at, input int len);
    int ep, eb, epd, eo;
    acc_arr.delete(); acc_start.delete(); exp_q.delete();
    drop_cyc   = -1;
    prev_press = 1'b0;
    bus.pulse  = 1'b0;
    rst        = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < len; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        acc_arr.delete(); acc_start.delete(); exp_q.delete();
        drop_cyc = -1;
      end else if (k == rst_at + 1) begin
        rst = 1'b0;
      end
      bus.pulse = pat[k];
      if (pat[k]) model_pulse(k);
      @(negedge clk);
      model_out(k, ep, eb, epd, eo);
      check($sformatf("%s.press@%0d", name, k), int'(bus.press), ep);
      check($sformatf("%s.busy@%0d", name, k), int'(bus.busy), eb);
      check($sformatf("%s.pend@%0d", name, k), int'(bus.pend), epd);
      check($sformatf("%s.ovf@%0d", name, k), int'(bus.ovf), eo);
      if (bus.press && !prev_press) begin
        if (exp_q.size() == 0) check($sformatf("%s.rise", name), k, -1);
        else                   check($sformatf("%s.rise", name), k, exp_q.pop_front());
      end
      prev_press = bus.press;
      @(posedge clk);
      #1;
    end
    check($sformatf("%s.sb_left", name), exp_q.size(), 0);
    bus.pulse = 1'b0;
  endtask

  initial begin
    logic [127:0] pat;
    bus.pulse = 1'b0;

    pat = '0; pat[10] = 1'b1;
    run_scn("single", pat, -10, 30);

    pat = '0; pat[10] = 1'b1; pat[12] = 1'b1; pat[14] = 1'b1;
    pat[16] = 1'b1; pat[18] = 1'b1;
    run_scn("fill", pat, -10, 70);

    pat = '0; pat[10] = 1'b1; pat[22] = 1'b1;
    run_scn("lastgap", pat, -10, 45);

    pat = '0; pat[10] = 1'b1; pat[12] = 1'b1; pat[22] = 1'b1;
    run_scn("simul", pat, -10, 55);

    pat = '0; pat[10] = 1'b1; pat[11] = 1'b1; pat[12] = 1'b1; pat[20] = 1'b1;
    run_scn("rstmid", pat, 14, 45);

    pat = '0;
    for (int k = 10; k <= 16; k++) pat[k] = 1'b1;
    run_scn("burst", pat, -10, 75);

    pat = '0;
    for (int k = 5; k < 60; k++) pat[k] = ($urandom_range(0, 3) == 0);
    run_scn("rand", pat, -10, 120);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
